// File: rtl/io_bus_controller.sv
// Memory-mapped I/O bus controller for EX/MEM: stalls the pipeline and runs a 4-phase req/ack
// handshake. Define IO_TIMEOUT_EN to build the request timeout with sticky io_err.
module io_bus_controller #(
  parameter logic [3:0]  IO_BASE  = 4'hF,
  parameter int          PADDR_W  = 8,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               iord_stall,
  output logic [31:0]        io_rdata,
  output logic               io_rdata_valid,
  output logic               io_err,
  output logic               per_req,
  output logic               per_we,
  output logic [PADDR_W-1:0] per_addr,
  output logic [31:0]        per_wdata,
  input  logic               per_ack,
  input  logic [31:0]        per_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_REL, S_DONE} state_t;

  state_t               r_state;
  logic                 r_req;
  logic                 r_we;
  logic [PADDR_W-1:0]   r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic                 r_rvalid;
  logic                 w_io_hit;
  logic                 w_unused_addr;

  assign w_io_hit      = (mem_read | mem_write) && (mem_addr[31:28] == IO_BASE);
  assign w_unused_addr = ^{mem_addr[27:PADDR_W+2], mem_addr[1:0]};

  // Gated by reset so an abandoned access releases the pipeline immediately.
  assign iord_stall = reset & (((r_state == S_IDLE) & w_io_hit) |
                               (r_state == S_REQ) | (r_state == S_WAIT_REL));

  assign per_req        = r_req;
  assign per_we         = r_we;
  assign per_addr       = r_addr;
  assign per_wdata      = r_wdata;
  assign io_rdata       = r_rdata;
  assign io_rdata_valid = r_rvalid;

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign io_err = r_err;
`else
  assign io_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
`ifdef IO_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_io_hit) begin
            r_we    <= mem_write;
            r_addr  <= mem_addr[PADDR_W+1:2];
            r_wdata <= mem_wdata;
            r_req   <= 1'b1;
            r_state <= S_REQ;
`ifdef IO_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (per_ack) begin
            if (!r_we) r_rdata <= per_rdata;
            r_req   <= 1'b0;
            r_state <= S_WAIT_REL;
          end
`ifdef IO_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Abort: skip WAIT_REL so a late ack never completes this access.
            if (!r_we) r_rdata <= ERR_DATA;
            r_req    <= 1'b0;
            r_err    <= 1'b1;
            r_rvalid <= ~r_we;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_WAIT_REL: begin
          if (!per_ack) begin
            r_rvalid <= ~r_we;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_bus_controller.md
Name: io_bus_controller

Overview:
- Memory-mapped I/O bus controller on the EX/MEM stage of the pipelined MIPS core.
- Decodes loads/stores to the I/O window and runs a 4-phase req/ack handshake with a peripheral.
- Drives `iord_stall` into the hazard unit's `EXMEM_iord` input, so the pipeline holds until the access completes and read data is ready for MEM/WB.

Parameters:
- `IO_BASE`, 4'hF: value of `mem_addr[31:28]` that selects the I/O window.
- `PADDR_W`, 8: peripheral address width; `per_addr = mem_addr[PADDR_W+1:2]` (word address).
- `TIMEOUT`, 255: cycles `per_req` may wait for `per_ack` before abort (only with `IO_TIMEOUT_EN`).
- `ERR_DATA`, 32'hFFFFFFFF: read data returned on timeout.

Ports:
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mem_addr` input 32: EX/MEM ALU result (address).
- `mem_wdata` input 32: EX/MEM store data.
- `mem_read` input 1: EX/MEM load control.
- `mem_write` input 1: EX/MEM store control.
- `iord_stall` output 1: to hazard unit `EXMEM_iord`; high = freeze PC, IF/ID, bubble.
- `io_rdata` output 32: captured peripheral read data.
- `io_rdata_valid` output 1: one-cycle pulse; `io_rdata` is valid for the held load.
- `io_err` output 1: sticky timeout flag.
- `per_req` output 1: peripheral request.
- `per_we` output 1: 1 = write, 0 = read; stable while `per_req` is high.
- `per_addr` output `PADDR_W`: peripheral word address.
- `per_wdata` output 32: peripheral write data.
- `per_ack` input 1: peripheral acknowledge.
- `per_rdata` input 32: peripheral read data; valid while `per_ack` is high.

Behaviour:
- Definitions:
  - `io_hit = (mem_read | mem_write) & (mem_addr[31:28] == IO_BASE)`.
  - `mem_read` and `mem_write` both high is treated as a write.
- Reset values (asynchronous, `reset` = 0):
  - state = IDLE.
  - `per_req`, `per_we`, `io_rdata_valid`, `io_err` = 0.
  - `io_rdata`, `per_addr`, `per_wdata` = 0.
  - Reset mid-transaction drops `per_req` immediately. The peripheral must tolerate an abandoned handshake.
- FSM states: IDLE, REQ, WAIT_REL, DONE.
- IDLE:
  - `iord_stall = io_hit` (combinational, so the stall takes effect in the same cycle the access reaches EX/MEM).
  - On `io_hit`: latch `per_we`, `per_addr`, `per_wdata`; clear the timeout counter; go to REQ.
  - Non-I/O accesses: no stall, no bus activity.
- REQ:
  - `per_req = 1`, `iord_stall = 1`.
  - `per_ack` sampled high: capture `per_rdata` into `io_rdata` if read; go to WAIT_REL.
  - Otherwise increment the counter (see Optional Feature).
- WAIT_REL:
  - `per_req = 0`, `iord_stall = 1`.
  - Stay until `per_ack` is sampled low, then go to DONE.
- DONE:
  - `iord_stall = 0`.
  - `io_rdata_valid = 1` if the access was a read.
  - Unconditionally go to IDLE. The held instruction leaves EX/MEM on this edge.
- Outputs `per_req` and `io_rdata_valid` are registered, not decoded from inputs.
- Latency: with the peripheral acking in the first REQ cycle and releasing in the next, the stall is high for exactly 3 cycles (IDLE-hit, REQ, WAIT_REL), and DONE is the 4th cycle.
- Back-to-back I/O accesses: after DONE, IDLE re-evaluates `io_hit` for the next instruction. There is no lost or duplicated access.
- `per_ack` high while in IDLE or DONE is ignored.
- `io_rdata` holds its value until the next read capture. Writes leave it unchanged.

Optional Feature:
- Macro `IO_TIMEOUT_EN`.
- When defined:
  - In REQ, the counter increments each cycle `per_ack` is low.
  - When the counter reaches `TIMEOUT`: drop `per_req`, load `io_rdata = ERR_DATA` (reads), set `io_err` (sticky until reset), go directly to DONE.
  - A late `per_ack` is ignored.
- When not defined:
  - REQ waits indefinitely.
  - No counter is built; `io_err` is tied to 0.

Test Plan:
1. Reset held low, then released:
   - all outputs 0, `iord_stall` = 0 for `mem_read` = 1, `mem_addr` = 0x0000_0040 (non-I/O).
2. Load from 0xF000_0010; peripheral acks in the cycle after `per_req` rises with `per_rdata` = 0x1234_5678, then deasserts:
   - `per_addr` = 8'h04, `per_we` = 0, stall high 3 cycles.
   - `io_rdata` = 0x1234_5678.
   - `io_rdata_valid` pulses 1 cycle with stall low.
3. Store 0xCAFE_BABE to 0xF000_0020; ack delayed 5 cycles:
   - `per_we` = 1, `per_wdata` = 0xCAFE_BABE, stall held for the whole wait.
   - no `io_rdata_valid`; `io_rdata` unchanged.
4. Two consecutive I/O loads (addresses 0xF000_0000, 0xF000_0004):
   - two complete handshakes, `per_addr` 0x00 then 0x01.
   - two `io_rdata_valid` pulses, `per_req` low between them.
5. `reset` asserted while in REQ:
   - `per_req` and `iord_stall` drop asynchronously; state is IDLE after release.
6. With `IO_TIMEOUT_EN`, `TIMEOUT` = 4, load with no ack:
   - `per_req` drops after 4 REQ cycles.
   - `io_rdata` = 0xFFFF_FFFF, `io_err` = 1 and stays 1 through subsequent good accesses.
